// File: rtl/ef_sram_mp_adapter_if.sv
// Fabric-side request/response bundle for the multi-port SRAM adapter.
// Ports: per-port req_valid/ready/we/addr/wdata/be in, per-port rsp_valid and shared rsp_data out.
interface ef_sram_mp_adapter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_PORTS  = 2
);
    localparam int BE_W = DATA_WIDTH / 8;

    logic [NUM_PORTS-1:0]            req_valid;
    logic [NUM_PORTS-1:0]            req_ready;
    logic [NUM_PORTS-1:0]            req_we;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_PORTS*BE_W-1:0]       req_be;
    logic [NUM_PORTS-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]           rsp_data;

    // Fabric requesters drive requests and consume grants/responses.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_data
    );

    // The adapter consumes requests and produces grants/responses.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/ef_sram_mp_adapter.sv
// Round-robin multi-port fabric adapter onto one single-port EF_SRAM macro.
// Ports: UserCLK/RST, fabric bus (slave modport), registered *_SRAM macro pins, DO_SRAM read data in.
module ef_sram_mp_adapter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_PORTS  = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic                  UserCLK,
    input  logic                  RST,
    ef_sram_mp_adapter_if.slave   bus,
    output logic                  CLOCK_SRAM,
    output logic                  EN_SRAM,
    output logic                  R_WB_SRAM,
    output logic [ADDR_WIDTH-1:0] AD_SRAM,
    output logic [DATA_WIDTH-1:0] DI_SRAM,
    output logic [DATA_WIDTH-1:0] BEN_SRAM,
    input  logic [DATA_WIDTH-1:0] DO_SRAM
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // Arbitration state: last granted port.
    logic [PW-1:0]          r_ptr;

    // Registered macro pins.
    logic                   r_en;
    logic                   r_rwb;
    logic [ADDR_WIDTH-1:0]  r_ad;
    logic [DATA_WIDTH-1:0]  r_di;
    logic [DATA_WIDTH-1:0]  r_ben;

    // Read tag pipeline: stage j holds a read accepted j edges ago.
    logic [RD_LATENCY:0]         r_tag_v;
    logic [RD_LATENCY:0][PW-1:0] r_tag_p;

    // Response registers.
    logic [NUM_PORTS-1:0]   r_rsp_valid;
    logic [DATA_WIDTH-1:0]  r_rsp_data;

    // Grant / selected request.
    logic [NUM_PORTS-1:0]   w_ready;
    logic                   w_accept;
    logic [PW-1:0]          w_gidx;
    logic                   w_we;
    logic [ADDR_WIDTH-1:0]  w_addr;
    logic [DATA_WIDTH-1:0]  w_wdata;
    logic [BE_W-1:0]        w_be;
    logic [DATA_WIDTH-1:0]  w_ben;

    // Search upward from the port after the pointer; first valid wins.
    always_comb begin
        int idx;
        idx      = 0;
        w_ready  = '0;
        w_gidx   = '0;
        w_accept = 1'b0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            idx = (int'(r_ptr) + off) % NUM_PORTS;
            if (!w_accept && bus.req_valid[idx]) begin
                w_accept     = 1'b1;
                w_ready[idx] = 1'b1;
                w_gidx       = PW'(idx);
            end
        end
        if (RST) begin
            w_ready  = '0;
            w_accept = 1'b0;
        end
    end

    assign bus.req_ready = w_ready;

    assign w_we    = bus.req_we[w_gidx];
    assign w_addr  = bus.req_addr[int'(w_gidx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata = bus.req_wdata[int'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];
    assign w_be    = bus.req_be[int'(w_gidx)*BE_W +: BE_W];

    // Byte enables fan out to 8 bit enables; reads enable every bit.
    always_comb begin
        w_ben = '1;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            w_ben[b] = w_we ? w_be[b/8] : 1'b1;
        end
    end

    always_ff @(posedge UserCLK) begin
        if (RST) begin
            r_ptr <= PW'(NUM_PORTS - 1);
        end else if (w_accept) begin
            r_ptr <= w_gidx;
        end
    end

    // Pins carry an accepted request for one cycle, then return to idle.
    always_ff @(posedge UserCLK) begin
        if (RST) begin
            r_en  <= 1'b0;
            r_rwb <= 1'b1;
            r_ad  <= '0;
            r_di  <= '0;
            r_ben <= '0;
        end else if (w_accept) begin
            r_en  <= 1'b1;
            r_rwb <= ~w_we;
            r_ad  <= w_addr;
            r_di  <= w_wdata;
            r_ben <= w_ben;
        end else begin
            r_en  <= 1'b0;
            r_rwb <= 1'b1;
        end
    end

    always_ff @(posedge UserCLK) begin
        if (RST) begin
            r_tag_v <= '0;
            r_tag_p <= '0;
        end else begin
            r_tag_v <= {r_tag_v[RD_LATENCY-1:0], w_accept & ~w_we};
            r_tag_p <= {r_tag_p[RD_LATENCY-1:0], w_gidx};
        end
    end

    // Last tag stage lines up with DO_SRAM being valid.
    always_ff @(posedge UserCLK) begin
        if (RST) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (r_tag_v[RD_LATENCY]) begin
                r_rsp_valid[r_tag_p[RD_LATENCY]] <= 1'b1;
                r_rsp_data                       <= DO_SRAM;
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;

    assign CLOCK_SRAM = UserCLK;
    assign EN_SRAM    = r_en;
    assign R_WB_SRAM  = r_rwb;
    assign AD_SRAM    = r_ad;
    assign DI_SRAM    = r_di;
    assign BEN_SRAM   = r_ben;
endmodule

// File: tb/tb_ef_sram_mp_adapter.sv
// Bench for ef_sram_mp_adapter: two instances (read latency 1 and 3) share one stimulus.
// A behavioural model predicts grants, macro pins and responses every cycle.
module tb_ef_sram_mp_adapter;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int NP = 2;
    localparam int LA = 1;
    localparam int LB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    ef_sram_mp_adapter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PORTS(NP)) ia ();
    ef_sram_mp_adapter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PORTS(NP)) ib ();

    assign ib.req_valid = ia.req_valid;
    assign ib.req_we    = ia.req_we;
    assign ib.req_addr  = ia.req_addr;
    assign ib.req_wdata = ia.req_wdata;
    assign ib.req_be    = ia.req_be;

    logic          clk_a, en_a, rwb_a, clk_b, en_b, rwb_b;
    logic [AW-1:0] ad_a, ad_b;
    logic [DW-1:0] di_a, ben_a, do_a, di_b, ben_b, do_b;

    ef_sram_mp_adapter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PORTS(NP), .RD_LATENCY(LA)) dut_a (
        .UserCLK(clk), .RST(rst), .bus(ia),
        .CLOCK_SRAM(clk_a), .EN_SRAM(en_a), .R_WB_SRAM(rwb_a),
        .AD_SRAM(ad_a), .DI_SRAM(di_a), .BEN_SRAM(ben_a), .DO_SRAM(do_a)
    );

    ef_sram_mp_adapter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PORTS(NP), .RD_LATENCY(LB)) dut_b (
        .UserCLK(clk), .RST(rst), .bus(ib),
        .CLOCK_SRAM(clk_b), .EN_SRAM(en_b), .R_WB_SRAM(rwb_b),
        .AD_SRAM(ad_b), .DI_SRAM(di_b), .BEN_SRAM(ben_b), .DO_SRAM(do_b)
    );

    function automatic logic [DW-1:0] pat(int a);
        return 32'hC0DE0000 + 32'(a);
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- macro emulation (stimulus side) ----------------
    logic [DW-1:0] sm_a [0:1023];
    logic [DW-1:0] sm_b [0:1023];
    logic [DW-1:0] dq_b [0:2];
    logic [DW-1:0] em   [0:1023];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sm_a[i] = pat(i);
            sm_b[i] = pat(i);
            em[i]   = pat(i);
        end
    end

    always @(posedge clk) begin
        if (en_a === 1'b1 && rwb_a === 1'b0)
            sm_a[ad_a] <= (sm_a[ad_a] & ~ben_a) | (di_a & ben_a);
        do_a <= (en_a === 1'b1 && rwb_a === 1'b1) ? sm_a[ad_a] : (32'hBAD00000 | 32'(cyc));
    end

    always @(posedge clk) begin
        if (en_b === 1'b1 && rwb_b === 1'b0)
            sm_b[ad_b] <= (sm_b[ad_b] & ~ben_b) | (di_b & ben_b);
        dq_b[0] <= (en_b === 1'b1 && rwb_b === 1'b1) ? sm_b[ad_b] : (32'hBAD10000 | 32'(cyc));
        dq_b[1] <= dq_b[0];
        dq_b[2] <= dq_b[1];
    end
    assign do_b = dq_b[2];

    // ---------------- behavioural model ----------------
    typedef struct {
        int            due;
        int            port;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          qa[$];
    rsp_t          qb[$];
    int            mptr = NP - 1;
    bit            minit = 1'b0;
    logic          me_en, me_rwb;
    logic [AW-1:0] me_ad;
    logic [DW-1:0] me_di, me_ben, ma_rd, mb_rd;

    // Next port in cyclic order after ptr that is requesting, or -1.
    function automatic int pick(logic [NP-1:0] v, int ptr);
        int i;
        i = ptr;
        repeat (NP) begin
            i = i + 1;
            if (i == NP) i = 0;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model
        int p;
        cyc++;
        if (rst) begin
            minit  = 1'b1;
            mptr   = NP - 1;
            qa.delete();
            qb.delete();
            me_en  = 1'b0;
            me_rwb = 1'b1;
            me_ad  = '0;
            me_di  = '0;
            me_ben = '0;
            ma_rd  = '0;
            mb_rd  = '0;
        end else begin
            p = pick(ia.req_valid, mptr);
            if (p >= 0) begin
                mptr   = p;
                me_en  = 1'b1;
                me_rwb = ~ia.req_we[p];
                me_ad  = ia.req_addr[p*AW +: AW];
                me_di  = ia.req_wdata[p*DW +: DW];
                for (int b = 0; b < DW; b++)
                    me_ben[b] = ia.req_we[p] ? ia.req_be[p*(DW/8) + b/8] : 1'b1;
                if (ia.req_we[p]) begin
                    em[me_ad] = (em[me_ad] & ~me_ben) | (me_di & me_ben);
                end else begin
                    qa.push_back('{cyc + LA + 1, p, em[me_ad]});
                    qb.push_back('{cyc + LB + 1, p, em[me_ad]});
                end
            end else begin
                me_en  = 1'b0;
                me_rwb = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : cmp
        logic [NP-1:0] er, ea, eb;
        int p;
        if (minit) begin
            er = '0;
            if (!rst) begin
                p = pick(ia.req_valid, mptr);
                if (p >= 0) er[p] = 1'b1;
            end
            chk("ready_a", ia.req_ready, er);
            chk("ready_b", ib.req_ready, er);
            chk("clk_sram_a", clk_a, clk);
            chk("en_a", en_a, me_en);
            chk("rwb_a", rwb_a, me_rwb);
            chk("ad_a", ad_a, me_ad);
            chk("di_a", di_a, me_di);
            chk("ben_a", ben_a, me_ben);
            chk("en_b", en_b, me_en);
            chk("rwb_b", rwb_b, me_rwb);
            chk("ad_b", ad_b, me_ad);
            chk("ben_b", ben_b, me_ben);
            ea = '0;
            if (qa.size() > 0 && qa[0].due == cyc) begin
                ea[qa[0].port] = 1'b1;
                ma_rd = qa[0].data;
                void'(qa.pop_front());
            end
            eb = '0;
            if (qb.size() > 0 && qb[0].due == cyc) begin
                eb[qb[0].port] = 1'b1;
                mb_rd = qb[0].data;
                void'(qb.pop_front());
            end
            chk("rsp_valid_a", ia.rsp_valid, ea);
            chk("rsp_data_a", ia.rsp_data, ma_rd);
            chk("rsp_valid_b", ib.rsp_valid, eb);
            chk("rsp_data_b", ib.rsp_data, mb_rd);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int p, bit v, bit we, logic [AW-1:0] a, logic [DW-1:0] d, logic [3:0] be);
        ia.req_valid[p]         = v;
        ia.req_we[p]            = we;
        ia.req_addr[p*AW +: AW] = a;
        ia.req_wdata[p*DW +: DW] = d;
        ia.req_be[p*4 +: 4]     = be;
    endtask

    task automatic do_rst;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // Write then read the same address back to back on port 0 (latency-1 instance).
    task automatic wr_rd(string tg, logic [AW-1:0] a, logic [DW-1:0] d, logic [3:0] be,
                         logic [DW-1:0] xben, logic [DW-1:0] xrd);
        set_req(0, 1'b1, 1'b1, a, d, be);
        @(negedge clk);
        chk({tg, "_wr_ready"}, ia.req_ready, 2'b01);
        tick;
        set_req(0, 1'b1, 1'b0, a, d, be);
        @(negedge clk);
        chk({tg, "_wr_en"}, en_a, 1'b1);
        chk({tg, "_wr_rwb"}, rwb_a, 1'b0);
        chk({tg, "_wr_ben"}, ben_a, xben);
        chk({tg, "_rd_ready"}, ia.req_ready, 2'b01);
        tick;
        ia.req_valid[0] = 1'b0;
        @(negedge clk);
        chk({tg, "_rd_en"}, en_a, 1'b1);
        chk({tg, "_rd_rwb"}, rwb_a, 1'b1);
        tick;
        @(negedge clk);
        chk({tg, "_rsp_early"}, ia.rsp_valid, 2'b00);
        tick;
        @(negedge clk);
        chk({tg, "_rsp_valid"}, ia.rsp_valid, 2'b01);
        chk({tg, "_rsp_data"}, ia.rsp_data, xrd);
        tick;
    endtask

    initial begin : stim
        int nrsp;
        int k;
        int d;
        bit xv;
        ia.req_valid = '0;
        ia.req_we    = '0;
        ia.req_addr  = '0;
        ia.req_wdata = '0;
        ia.req_be    = '0;
        rst = 1'b1;
        repeat (3) tick;
        rst = 1'b0;

        // 1: idle after reset
        repeat (5) begin
            @(negedge clk);
            chk("t1_en", en_a, 1'b0);
            chk("t1_rwb", rwb_a, 1'b1);
            chk("t1_rsp", ia.rsp_valid, 2'b00);
            chk("t1_ready", ia.req_ready, 2'b00);
        end
        tick;

        // 2, 3: full then partial write with readback
        wr_rd("t2", 10'h005, 32'hDEADBEEF, 4'b1111, 32'hFFFFFFFF, 32'hDEADBEEF);
        wr_rd("t3", 10'h005, 32'h0000AA00, 4'b0010, 32'h0000FF00, 32'hDEADAAEF);

        // 4: two ports contend for six cycles
        do_rst;
        set_req(0, 1'b1, 1'b0, 10'h001, '0, 4'h0);
        set_req(1, 1'b1, 1'b0, 10'h002, '0, 4'h0);
        nrsp = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i < 6)
                chk("t4_grant", ia.req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (ia.rsp_valid != 2'b00) begin
                chk("t4_rsp_port", ia.rsp_valid, (nrsp % 2 == 0) ? 2'b01 : 2'b10);
                chk("t4_rsp_data", ia.rsp_data, (nrsp % 2 == 0) ? 32'hC0DE0001 : 32'hC0DE0002);
                nrsp++;
            end
            tick;
            if (i == 5) ia.req_valid = '0;
        end
        chk("t4_rsp_count", nrsp, 6);

        // 5: four back-to-back reads, checked on the latency-3 instance
        k = 0;
        set_req(0, 1'b1, 1'b0, 10'h010, '0, 4'h0);
        for (int j = 0; j < 4; j++) begin
            tick;
            if (j == 0) k = cyc;
            ia.req_addr[AW-1:0] = 10'(16 + j + 1);
        end
        ia.req_valid = '0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            d  = cyc - k;
            xv = (d >= 4 && d <= 7);
            chk("t5_rv_b", ib.rsp_valid, {1'b0, xv});
            if (xv) chk("t5_rd_b", ib.rsp_data, 32'hC0DE0010 + 32'(d - 4));
            tick;
        end

        // 6: reset one cycle after a read accept drops the read
        set_req(1, 1'b1, 1'b0, 10'h003, '0, 4'h0);
        @(negedge clk);
        chk("t6_rd_ready", ia.req_ready, 2'b10);
        tick;
        ia.req_valid = '0;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("t6_no_rsp_a", ia.rsp_valid, 2'b00);
            chk("t6_no_rsp_b", ib.rsp_valid, 2'b00);
            tick;
        end
        set_req(0, 1'b1, 1'b0, 10'h007, '0, 4'h0);
        set_req(1, 1'b1, 1'b0, 10'h008, '0, 4'h0);
        @(negedge clk);
        chk("t6_first", ia.req_ready, 2'b01);
        tick;
        ia.req_valid[0] = 1'b0;
        @(negedge clk);
        chk("t6_second", ia.req_ready, 2'b10);
        tick;
        ia.req_valid = '0;
        repeat (8) tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: sim time %0t, expected finish before limit", $time);
        $fatal(1);
    end
endmodule
